// File: rtl/bytes_to_bridge.sv
// Byte-wide initiator onto a 32-bit word-only bus through a one-word write-combining/read buffer.
// Big-endian lanes (offset 0 = bits [31:24]); partial words are completed by read-modify-write.
module bytes_to_bridge #(
  parameter int CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bytes_addr,
  input  logic        bytes_wr,
  input  logic        bytes_rd,
  input  logic [7:0]  bytes_wr_data,
  output logic [7:0]  bytes_rd_data,
  output logic        bytes_rd_data_valid,
  output logic [31:0] word_addr,
  output logic        word_wr,
  output logic        word_rd,
  output logic [31:0] word_wr_data,
  input  logic [31:0] word_rd_data,
  input  logic        word_rd_data_valid,
  input  logic        flush,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, WB_RD, WB_RDWAIT, WB_WR, FILL_RD, FILL_WAIT, RESPOND} state_t;
  localparam int GW = $clog2(CYCLES + 1) + 1;
  localparam logic [GW-1:0] CYC = GW'(CYCLES);

  state_t        state_q, state_d;
  logic [29:0]   buf_addr_q, buf_addr_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [3:0]    dirty_q, dirty_d;
  logic          filled_q, filled_d;
  logic          pend_rd_q, pend_rd_d;
  logic          pend_wr_q, pend_wr_d;
  logic          pend_flush_q, pend_flush_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_vld_q, rd_vld_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          gap_ok;
  logic          pulse;

  function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] l);
    return w[{~l, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] l,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{~l, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [3:0] lane_bit(input logic [1:0] l);
    return 4'b0001 << l;
  endfunction

  // Memory data only fills lanes the initiator has not overwritten.
  function automatic logic [31:0] merge_mem(input logic [31:0] w, input logic [31:0] m,
                                            input logic [3:0] d);
    logic [31:0] r;
    logic [1:0]  li;
    r = w;
    for (int i = 0; i < 4; i++) begin
      li = 2'(i);
      if (!d[i]) r[{~li, 3'b000} +: 8] = m[{~li, 3'b000} +: 8];
    end
    return r;
  endfunction

  function automatic state_t wb_state(input logic [3:0] d, input logic f);
    return (d == 4'hf || f) ? WB_WR : WB_RD;
  endfunction

  assign gap_ok = (gap_q >= CYC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      dirty_q      <= '0;
      filled_q     <= 1'b0;
      pend_rd_q    <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_flush_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      rd_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      gap_q        <= CYC;
    end else begin
      state_q      <= state_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      dirty_q      <= dirty_d;
      filled_q     <= filled_d;
      pend_rd_q    <= pend_rd_d;
      pend_wr_q    <= pend_wr_d;
      pend_flush_q <= pend_flush_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      rd_data_q    <= rd_data_d;
      rd_vld_q     <= rd_vld_d;
      gap_q        <= gap_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    dirty_d      = dirty_q;
    filled_d     = filled_q;
    pend_rd_d    = pend_rd_q;
    pend_wr_d    = pend_wr_q;
    pend_flush_d = pend_flush_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    rd_data_d    = rd_data_q;
    rd_vld_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bytes_rd) begin
          if (filled_q && bytes_addr[31:2] == buf_addr_q) begin
            rd_data_d = get_lane(buf_data_q, bytes_addr[1:0]);
            rd_vld_d  = 1'b1;
            if (flush && dirty_q != 4'h0) state_d = wb_state(dirty_q, filled_q);
          end else begin
            pend_rd_d    = 1'b1;
            pend_addr_d  = bytes_addr;
            pend_flush_d = flush;
            state_d      = (dirty_q != 4'h0) ? wb_state(dirty_q, filled_q) : FILL_RD;
          end
        end else if (bytes_wr) begin
          if (bytes_addr[31:2] == buf_addr_q || dirty_q == 4'h0) begin
            buf_data_d = set_lane(buf_data_q, bytes_addr[1:0], bytes_wr_data);
            if (bytes_addr[31:2] == buf_addr_q) begin
              dirty_d = dirty_q | lane_bit(bytes_addr[1:0]);
            end else begin
              buf_addr_d = bytes_addr[31:2];
              dirty_d    = lane_bit(bytes_addr[1:0]);
              filled_d   = 1'b0;
            end
            if (dirty_d == 4'hf) state_d = WB_WR;
            else if (flush)      state_d = wb_state(dirty_d, filled_d);
          end else begin
            pend_wr_d    = 1'b1;
            pend_addr_d  = bytes_addr;
            pend_data_d  = bytes_wr_data;
            pend_flush_d = flush;
            state_d      = wb_state(dirty_q, filled_q);
          end
        end else if (flush && dirty_q != 4'h0) begin
          state_d = wb_state(dirty_q, filled_q);
        end
      end
      WB_RD:   if (gap_ok) state_d = WB_RDWAIT;
      WB_RDWAIT: begin
        if (word_rd_data_valid) begin
          buf_data_d = merge_mem(buf_data_q, word_rd_data, dirty_q);
          state_d    = WB_WR;
        end
      end
      WB_WR: begin
        if (gap_ok) begin
          dirty_d  = 4'h0;
          filled_d = 1'b1;
          if (pend_rd_q) begin
            if (pend_addr_q[31:2] == buf_addr_q) begin
              rd_data_d    = get_lane(buf_data_q, pend_addr_q[1:0]);
              rd_vld_d     = 1'b1;
              pend_rd_d    = 1'b0;
              pend_flush_d = 1'b0;
              state_d      = RESPOND;
            end else begin
              state_d = FILL_RD;
            end
          end else if (pend_wr_q) begin
            // Allocate the deferred write without a fill; a queued flush then writes it back.
            pend_wr_d    = 1'b0;
            pend_flush_d = 1'b0;
            buf_addr_d   = pend_addr_q[31:2];
            buf_data_d   = set_lane(buf_data_q, pend_addr_q[1:0], pend_data_q);
            dirty_d      = lane_bit(pend_addr_q[1:0]);
            filled_d     = (pend_addr_q[31:2] == buf_addr_q);
            state_d      = pend_flush_q ? wb_state(dirty_d, filled_d) : IDLE;
          end else begin
            pend_flush_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      FILL_RD: if (gap_ok) state_d = FILL_WAIT;
      FILL_WAIT: begin
        if (word_rd_data_valid) begin
          buf_addr_d = pend_addr_q[31:2];
          buf_data_d = word_rd_data;
          filled_d   = 1'b1;
          rd_data_d  = get_lane(word_rd_data, pend_addr_q[1:0]);
          rd_vld_d   = 1'b1;
          pend_rd_d  = 1'b0;
          state_d    = RESPOND;
        end
      end
      RESPOND: begin
        pend_flush_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pulse)             gap_d = GW'(1);
    else if (gap_q < CYC)  gap_d = gap_q + GW'(1);
    else                   gap_d = gap_q;
  end

  always_comb begin
    word_rd             = gap_ok && (state_q == WB_RD || state_q == FILL_RD);
    word_wr             = gap_ok && (state_q == WB_WR);
    pulse               = word_rd | word_wr;
    word_addr           = 32'h0;
    word_wr_data        = 32'h0;
    busy                = (state_q != IDLE);
    bytes_rd_data       = rd_data_q;
    bytes_rd_data_valid = rd_vld_q;
    case (state_q)
      WB_RD, WB_RDWAIT:   word_addr = {buf_addr_q, 2'b00};
      WB_WR: begin
        word_addr    = {buf_addr_q, 2'b00};
        word_wr_data = buf_data_q;
      end
      FILL_RD, FILL_WAIT: word_addr = {pend_addr_q[31:2], 2'b00};
      default:            word_addr = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_bytes_to_bridge.sv
// Bench for bytes_to_bridge: directed scenarios plus random byte traffic against a byte-array memory model.
module tb_bytes_to_bridge;
  localparam int CYC = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] bytes_addr = 32'h0;
  logic        bytes_wr = 1'b0;
  logic        bytes_rd = 1'b0;
  logic [7:0]  bytes_wr_data = 8'h0;
  logic [7:0]  bytes_rd_data;
  logic        bytes_rd_data_valid;
  logic [31:0] word_addr;
  logic        word_wr;
  logic        word_rd;
  logic [31:0] word_wr_data;
  logic [31:0] word_rd_data = 32'h0;
  logic        word_rd_data_valid = 1'b0;
  logic        flush = 1'b0;
  logic        busy;

  bytes_to_bridge #(.CYCLES(CYC)) dut (
    .clk(clk), .reset_n(reset_n),
    .bytes_addr(bytes_addr), .bytes_wr(bytes_wr), .bytes_rd(bytes_rd),
    .bytes_wr_data(bytes_wr_data), .bytes_rd_data(bytes_rd_data),
    .bytes_rd_data_valid(bytes_rd_data_valid),
    .word_addr(word_addr), .word_wr(word_wr), .word_rd(word_rd),
    .word_wr_data(word_wr_data), .word_rd_data(word_rd_data),
    .word_rd_data_valid(word_rd_data_valid),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } op_t;

  op_t         log_q[$];
  logic [31:0] mem [0:511];
  logic [7:0]  ref_mem [0:2047];
  int          cyc = 0;
  int          lat = 2;
  int          min_gap = 1000000;
  int          n_assert = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      32'h80:  return 32'hAABBCCDD;
      32'hC0:  return 32'h01020304;
      32'h140: return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  // Word responder with programmable read latency; logs every downstream pulse.
  initial begin
    int          rd_cnt;
    int          last_pulse;
    logic [31:0] rd_word;
    rd_cnt = 0;
    last_pulse = -1000;
    rd_word = 32'h0;
    for (int i = 0; i < 512; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      word_rd_data_valid = 1'b0;
      if (!reset_n) begin
        rd_cnt = 0;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          word_rd_data_valid = 1'b1;
          word_rd_data = rd_word;
        end
      end
      if (word_wr || word_rd) begin
        if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
        last_pulse = cyc;
        log_q.push_back('{word_wr, word_addr, (word_wr ? word_wr_data : 32'h0), cyc});
        if (word_wr) mem[word_addr[10:2]] = word_wr_data;
        else begin
          rd_word = mem[word_addr[10:2]];
          rd_cnt = lat;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check({"idle_", tag}, 32'(busy), 32'h0);
  endtask

  task automatic write_byte(input logic [31:0] a, input logic [7:0] d, input bit fl);
    bytes_addr = a; bytes_wr = 1'b1; bytes_wr_data = d; flush = fl;
    tick();
    bytes_wr = 1'b0; flush = 1'b0;
    wait_idle("wr");
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("fl");
  endtask

  // Returns the byte, cycles from request edge to valid, and how many of those samples had busy high.
  task automatic read_byte(input logic [31:0] a, input bit also_wr, input bit fl,
                           output logic [7:0] d, output int c, output int nbusy);
    bytes_addr = a; bytes_rd = 1'b1; bytes_wr = also_wr; bytes_wr_data = 8'h5A; flush = fl;
    tick();
    bytes_rd = 1'b0; bytes_wr = 1'b0; flush = 1'b0;
    c = 1;
    nbusy = busy ? 1 : 0;
    while (!bytes_rd_data_valid && c < 100) begin
      tick();
      c++;
      if (busy) nbusy++;
    end
    check("rd_valid", 32'(bytes_rd_data_valid), 32'h1);
    d = bytes_rd_data;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_word_rd"}, 32'(word_rd), 32'h0);
    check({tag, "_word_wr"}, 32'(word_wr), 32'h0);
    check({tag, "_word_addr"}, word_addr, 32'h0);
    check({tag, "_word_wr_data"}, word_wr_data, 32'h0);
    check({tag, "_rd_data"}, 32'(bytes_rd_data), 32'h0);
    check({tag, "_rd_vld"}, 32'(bytes_rd_data_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic check_op(input string tag, input int idx, input bit wr,
                          input logic [31:0] a, input logic [31:0] d);
    if (idx < log_q.size()) begin
      check({tag, "_kind"}, 32'(log_q[idx].wr), 32'(wr));
      check({tag, "_addr"}, log_q[idx].addr, a);
      if (wr) check({tag, "_data"}, log_q[idx].data, d);
    end else begin
      check({tag, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int          s, c, nb, bc;
    logic [7:0]  d;
    logic [31:0] a, w;
    logic [7:0]  wd;
    int          op;
    bit          fl;

    for (int i = 0; i < 512; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = w[8 * (3 - b) +: 8];
    end

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick();

    // Sequential load: four writes combine into one word write
    s = log_q.size();
    lat = 2;
    for (int i = 0; i < 4; i++) begin
      bytes_addr = 32'h100 + 32'(i); bytes_wr = 1'b1; bytes_wr_data = 8'(8'h11 * (i + 1));
      ref_mem[32'h100 + i] = bytes_wr_data;
      tick();
      if (i < 3) check("seq_busy_low", 32'(busy), 32'h0);
    end
    bytes_wr = 1'b0;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) bc++;
      tick();
    end
    check("seq_busy_cycles", 32'(bc), 32'h1);
    check("seq_nops", 32'(log_q.size() - s), 32'h1);
    check_op("seq_wr", s, 1'b1, 32'h100, 32'h11223344);

    // Partial flush: read-modify-write
    s = log_q.size();
    write_byte(32'h202, 8'h55, 1'b0);
    ref_mem[32'h202] = 8'h55;
    check("rmw_no_traffic_before_flush", 32'(log_q.size() - s), 32'h0);
    do_flush();
    check("rmw_nops", 32'(log_q.size() - s), 32'h2);
    check_op("rmw_rd", s, 1'b0, 32'h200, 32'h0);
    check_op("rmw_wr", s + 1, 1'b1, 32'h200, 32'hAABB55DD);
    s = log_q.size();
    do_flush();
    repeat (4) tick();
    check("rmw_clean_flush_noop", 32'(log_q.size() - s), 32'h0);

    // Read miss then back-to-back hits
    s = log_q.size();
    read_byte(32'h303, 1'b0, 1'b0, d, c, nb);
    check("miss_data", 32'(d), 32'h04);
    check("miss_latency", 32'(c), 32'(lat + 2));
    wait_idle("miss");
    read_byte(32'h300, 1'b0, 1'b0, d, c, nb);
    check("hit0_data", 32'(d), 32'h01);
    check("hit0_latency", 32'(c), 32'h1);
    read_byte(32'h301, 1'b0, 1'b0, d, c, nb);
    check("hit1_data", 32'(d), 32'h02);
    check("hit1_latency", 32'(c), 32'h1);
    check("hit_busy", 32'(nb), 32'h0);
    check("hit_nops", 32'(log_q.size() - s), 32'h1);
    check_op("hit_fill", s, 1'b0, 32'h300, 32'h0);
    repeat (3) tick();
    check("rd_data_held", 32'(bytes_rd_data), 32'h02);
    check("rd_vld_pulse", 32'(bytes_rd_data_valid), 32'h0);

    // Dirty eviction on read, with fast memory so pacing holds the write
    lat = 1;
    write_byte(32'h400, 8'h99, 1'b0);
    ref_mem[32'h400] = 8'h99;
    s = log_q.size();
    read_byte(32'h500, 1'b0, 1'b0, d, c, nb);
    wait_idle("evict");
    check("evict_data", 32'(d), 32'hCA);
    check("evict_nops", 32'(log_q.size() - s), 32'h3);
    check_op("evict_rd", s, 1'b0, 32'h400, 32'h0);
    check_op("evict_wr", s + 1, 1'b1, 32'h400, 32'h99000000);
    check_op("evict_fill", s + 2, 1'b0, 32'h500, 32'h0);
    if (log_q.size() >= s + 3)
      check("evict_pace", 32'(log_q[s + 1].cyc - log_q[s].cyc >= CYC), 32'h1);

    // Slow memory: busy throughout a long fill
    lat = 7;
    read_byte(32'h201, 1'b0, 1'b0, d, c, nb);
    check("slow_data", 32'(d), 32'hBB);
    check("slow_latency", 32'(c), 32'(lat + 2));
    check("slow_busy", 32'(nb), 32'(c));
    wait_idle("slow");

    // Reset during a fill
    lat = 20;
    bytes_addr = 32'h0; bytes_rd = 1'b1;
    tick();
    bytes_rd = 1'b0;
    repeat (3) tick();
    check("midfill_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midfill_reset");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    lat = 2;
    s = log_q.size();
    read_byte(32'h201, 1'b0, 1'b0, d, c, nb);
    wait_idle("post_reset");
    check("post_reset_data", 32'(d), 32'hBB);
    check("post_reset_nops", 32'(log_q.size() - s), 32'h1);
    check_op("post_reset_fill", s, 1'b0, 32'h200, 32'h0);

    // Random traffic against the byte-array model
    for (int k = 0; k < 250; k++) begin
      lat = $urandom_range(1, 4);
      a = 32'h600 + 32'($urandom_range(0, 23));
      op = $urandom_range(0, 99);
      fl = ($urandom_range(0, 9) == 0);
      if (op < 40) begin
        wd = 8'($urandom);
        write_byte(a, wd, fl);
        ref_mem[a[10:0]] = wd;
      end else if (op < 88) begin
        read_byte(a, op >= 80, fl, d, c, nb);
        check("rnd_rd", 32'(d), 32'(ref_mem[a[10:0]]));
        wait_idle("rnd");
      end else begin
        do_flush();
      end
    end
    do_flush();
    for (int i = 32'h180; i < 32'h186; i++)
      check("final_mem", mem[i], {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]});
    check("final_mem_100", mem[32'h40], 32'h11223344);
    check("final_mem_400", mem[32'h100], 32'h99000000);
    check("pace_min_gap", 32'(min_gap >= CYC), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bytes_to_bridge.md
# bytes_to_bridge

Adapts an 8-bit byte-wide initiator (core data port, byte loader, debug poke path) onto a 32-bit word-only bus_if responder (bridge-side RAM, PSRAM word controller). It keeps a one-word write-combining/read buffer: sequential byte writes are merged into a single 32-bit write, reads are served from the buffered word, and partial words are completed by read-modify-write. Byte order is big-endian: byte offset 0 maps to word bits [31:24] and offset 3 to [7:0].

## Interface
- CYCLES, 1: minimum cycles between successive downstream rd/wr pulses. Must be ≥1.
- clk  in  1  single clock, shared by both bus_if ports
- reset_n  in  1  asynchronous, active-low reset
- bytes  bus_if (responder side)  data 8  upstream byte port: addr, wr, rd, wr_data in; rd_data, rd_data_valid out
- word  bus_if (initiator side)  data 32  downstream port: addr, wr, rd, wr_data out; rd_data, rd_data_valid in. addr[1:0] is always 2'b00.
- flush  in  1  pulse: write back any dirty bytes
- busy  out  1  high while a downstream operation is pending; upstream must not issue rd/wr/flush while busy=1

## Operation
- State: buf_addr[31:2], buf_data[31:0], dirty[3:0] (lanes written but not yet in memory), filled (all non-dirty lanes hold memory contents).
- Hit means filled=1 and bytes.addr[31:2]==buf_addr.
- FSM states: IDLE, WB_RD, WB_RDWAIT, WB_WR, FILL_RD, FILL_WAIT, RESPOND.
- Read hit in IDLE: byte lane addr[1:0] returned; stays IDLE.
- Read miss:
  - If dirty≠0, write back first.
  - Then FILL_RD issues word.rd; FILL_WAIT loads buf_data and sets filled=1.
  - RESPOND returns the byte, then goes to IDLE.
- Write, same word (filled or not): merge byte into lane and set dirty bit. If dirty becomes 4'b1111, go to WB_WR (full-word write, no read).
- Write, other word: if dirty≠0, write back the old word first. Then allocate without fill: buf_addr=new word, only the written lane is dirty, filled=0.
- Write-back:
  - If dirty==1111 or filled=1: WB_WR only.
  - Otherwise WB_RD → WB_RDWAIT (merge memory data into non-dirty lanes only) → WB_WR.
  - After WB_WR: dirty=0, filled=1.
- flush in IDLE: write back if dirty≠0, otherwise no-op.
- The pending access is captured when issued and completed after any write-back or fill.
- rd and wr asserted together: rd wins, wr is dropped.
- Access and flush in the same cycle: the access is processed first, then the flush.
- Requests while busy=1 are ignored.

## Timing
- Reset: all outputs 0 (word.rd, word.wr, word.addr, word.wr_data, bytes.rd_data, bytes.rd_data_valid, busy); dirty=0, filled=0, FSM=IDLE. Reset mid-transaction abandons it; dirty data is lost.
- Read hit: bytes.rd at cycle N → bytes.rd_data_valid one-cycle pulse at N+1. busy stays 0, so back-to-back hits give one byte per cycle.
- Write hit that does not fill the word: 0 added latency, busy stays 0.
- busy rises the cycle after any request needing the downstream bus. It falls in the cycle the FSM returns to IDLE, or the cycle after RESPOND.
- word.rd and word.wr are single-cycle pulses with addr and wr_data stable in that cycle. Consecutive downstream pulses are separated by ≥CYCLES cycles.
- word.rd_data_valid may arrive any number of cycles after word.rd. Only the first pulse after a word.rd is used.
- Read miss with clean buffer: rd at N → word.rd at N+1 → if word.rd_data_valid at M, bytes.rd_data_valid at M+1.
- bytes.rd_data holds its value until the next response.

## Test plan
- Sequential load: write 0x11,0x22,0x33,0x44 to 0x100–0x103 back-to-back → exactly one word.wr, addr 0x100, data 0x11223344, no word.rd; busy high for 1 cycle.
- Partial flush RMW: memory[0x200]=0xAABBCCDD; write 0x55 to 0x202, then flush → word.rd 0x200, then word.wr 0x200 data 0xAABB55DD; dirty=0.
- Read miss then hits: memory[0x300]=0x01020304; read 0x303,0x300,0x301 → one word.rd; returns 0x04,0x01,0x02; the hits arrive with 1-cycle latency.
- Dirty eviction on read: write 0x99 to 0x400, then read 0x500 (memory[0x400]=0, memory[0x500]=0xCAFEF00D) → rd 0x400, wr 0x400 data 0x99000000, rd 0x500; returns 0xCA.
- Pacing/variable latency: CYCLES=3, word.rd_data_valid delayed 7 cycles → downstream pulses ≥3 apart, correct byte returned, busy high throughout.
- Reset mid-fill: assert reset_n=0 in FILL_WAIT → all outputs 0 immediately, busy=0; a later read issues a fresh word.rd.
